serial_addsub_ovf: RTL and testbench

- Bit-serial two's-complement adder/subtractor with overflow detection.
- Computes the same function as the parallel 8-bit add/sub datapath, but uses one single-bit full-adder cell reused over WIDTH cycles, LSB first.
- Sits behind a start/done handshake, so control logic can trade latency for area.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/fa_bit.sv | 14 +
 rtl/serial_addsub_ovf.sv | 98 +++++++++
 tb/tb_serial_addsub_ovf.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/sub unit.
// FSM state encoding and operation codes.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder cell.
// Reused every cycle by the serial datapath.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ovf.sv
// Bit-serial two's-complement add/sub, LSB first, with overflow.
// One full-adder cell, WIDTH shift cycles behind start/done.
module serial_addsub_ovf
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] p_sr;
    logic [WIDTH-1:0] p_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             c_n;
    logic             last;
    logic             is_sub;

    fa_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (s),
        .cout (c_n)
    );

    assign last   = (cnt == LAST);
    assign p_nxt  = {s, p_sr};
    assign is_sub = (sub == OP_SUB);
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state: accept in IDLE, run WIDTH bits, one DONE cycle
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // serial datapath: latch operands, shift one bit per cycle, commit on last
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            p_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{is_sub}};
            carry <= is_sub;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            p_sr  <= p_nxt[WIDTH-1:1];
            carry <= c_n;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                result   <= p_nxt;
                cout     <= c_n;
                overflow <= carry ^ c_n;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_ovf.sv
// Directed and exhaustive checks for serial_addsub_ovf.
// WIDTH=8 directed vectors plus a WIDTH=4 full sweep.
module tb_serial_addsub_ovf;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, sub8;
    logic [7:0] a8, b8, res8;
    logic       busy8, done8, cout8, ovf8;
    logic       start4, sub4;
    logic [3:0] a4, b4, res4;
    logic       busy4, done4, cout4, ovf4;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_addsub_ovf #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .sub      (sub8),
        .a        (a8),
        .b        (b8),
        .busy     (busy8),
        .done     (done8),
        .result   (res8),
        .cout     (cout8),
        .overflow (ovf8)
    );

    serial_addsub_ovf #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .sub      (sub4),
        .a        (a4),
        .b        (b4),
        .busy     (busy4),
        .done     (done4),
        .result   (res4),
        .cout     (cout4),
        .overflow (ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one 8-bit op issued now; checks latency, busy length, outputs, pulse
    task automatic run8(input string tag, input logic s, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] er,
                        input logic ec, input logic eo);
        int n;
        int bc;
        a8 = x; b8 = y; sub8 = s; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 1; bc = 0;
        while (!done8 && n < 40) begin
            if (busy8) bc++;
            tick();
            n++;
        end
        chk({tag, ".lat"}, n, 9);
        chk({tag, ".busy"}, bc, 8);
        chk({tag, ".res"}, res8, er);
        chk({tag, ".cout"}, cout8, ec);
        chk({tag, ".ovf"}, ovf8, eo);
        tick();
        chk({tag, ".pulse"}, done8, 0);
    endtask

    initial begin
        logic [4:0] full;
        logic [3:0] er;
        logic       eo;
        int         n;

        rst = 1'b1;
        start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
        start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
        tick(); tick();
        chk("rst.busy", busy8, 0);
        chk("rst.done", done8, 0);
        chk("rst.res", res8, 0);
        chk("rst.cout", cout8, 0);
        chk("rst.ovf", ovf8, 0);
        chk("rst.res4", res4, 0);
        rst = 1'b0;
        tick();

        run8("add127", 1'b0, 8'd100, 8'd27, 8'h7F, 1'b0, 1'b0);
        run8("add128", 1'b0, 8'd100, 8'd28, 8'h80, 1'b0, 1'b1);
        run8("addwrap", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run8("sub5m10", 1'b1, 8'd5, 8'd10, 8'hFB, 1'b0, 1'b0);
        run8("sub80m1", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // starts hammered while busy must be ignored
        a8 = 8'd100; b8 = 8'd27; sub8 = 1'b0; start8 = 1'b1;
        tick();
        n = 1;
        while (!done8 && n < 40) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            sub8 = 1'($urandom); start8 = 1'b1;
            tick();
            n++;
        end
        start8 = 1'b0;
        chk("b2b.lat", n, 9);
        chk("b2b.res", res8, 8'h7F);
        chk("b2b.cout", cout8, 0);
        chk("b2b.ovf", ovf8, 0);
        tick();
        tick();
        chk("b2b.idle", busy8, 0);

        // reset in the 4th SHIFT cycle drops the op and clears outputs
        a8 = 8'h33; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        chk("mid.busy", busy8, 1);
        chk("mid.hold", res8, 8'h7F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst.busy", busy8, 0);
        chk("mrst.done", done8, 0);
        chk("mrst.res", res8, 0);
        chk("mrst.cout", cout8, 0);
        chk("mrst.ovf", ovf8, 0);
        run8("after", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // exhaustive 4-bit sweep against a sign-rule reference
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    if (s == 0) full = 5'(x) + 5'(y);
                    else        full = 5'(x) + 5'(~y & 15) + 5'd1;
                    er = full[3:0];
                    if (s == 0)
                        eo = (x[3] == y[3]) && (er[3] != x[3]);
                    else
                        eo = (x[3] != y[3]) && (er[3] != x[3]);
                    a4 = 4'(x); b4 = 4'(y); sub4 = 1'(s); start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    n = 1;
                    while (!done4 && n < 30) begin
                        tick();
                        n++;
                    end
                    chk("w4.lat", n, 5);
                    chk("w4.res", res4, er);
                    chk("w4.cout", cout4, full[4]);
                    chk("w4.ovf", ovf4, eo);
                    tick();
                    chk("w4.pulse", done4, 0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
